// File: rtl/jtag_debug_cmd_queue.sv
// Carries virtual-JTAG update strobes from the TCK domain into the system clock and
// queues each captured {ir, data, action} update for the debug core (first-word-fall-through).
module jtag_debug_cmd_queue #(
  parameter int DR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ACTION_BIT  = DR_WIDTH - 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       vs_udr,
  input  logic                       vs_uir,
  input  logic [IR_WIDTH-1:0]        ir_in,
  input  logic [DR_WIDTH-1:0]        sr,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [IR_WIDTH-1:0]        cmd_ir,
  output logic [DR_WIDTH-1:0]        cmd_data,
  output logic                       cmd_take_action,
  output logic                       uir_pulse,
  output logic [$clog2(DEPTH+1)-1:0] fill_level,
  output logic                       overflow,
  input  logic                       clr_overflow
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam int ENT_W = IR_WIDTH + DR_WIDTH + 1;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
  localparam logic [ARM_W-1:0] ARM_ONE  = ARM_W'(1'b1);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] udr_sync_r;
  logic [SYNC_STAGES-1:0] uir_sync_r;
  logic                   udr_hist_r;
  logic                   uir_hist_r;
  logic [ARM_W-1:0]       arm_cnt_r;

  logic [ENT_W-1:0]       mem_r [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [CNT_W-1:0]       fill_r;
  logic [ENT_W-1:0]       head_r;
  logic                   valid_r;
  logic                   uir_pulse_r;
  logic                   overflow_r;

  logic                   armed_s;
  logic                   udr_edge_s;
  logic                   uir_edge_s;
  logic                   pop_s;
  logic                   full_s;
  logic                   push_s;
  logic                   drop_s;
  logic [ENT_W-1:0]       entry_s;
  logic [PTR_W-1:0]       rd_next_s;
  logic [ENT_W-1:0]       head_next_s;
  logic [CNT_W-1:0]       fill_next_s;

  // Edge detection, push/pop arbitration and next-head selection.
  always_comb begin
    armed_s    = (arm_cnt_r == ARM_DONE);
    udr_edge_s = armed_s & udr_sync_r[SYNC_STAGES-1] & ~udr_hist_r;
    uir_edge_s = armed_s & uir_sync_r[SYNC_STAGES-1] & ~uir_hist_r;
    pop_s      = valid_r & cmd_ready;
    full_s     = (fill_r == FULL_LVL);
    entry_s    = {ir_in, sr, sr[ACTION_BIT]};
    push_s     = udr_edge_s & (~full_s | pop_s);
    drop_s     = udr_edge_s & full_s & ~pop_s;

    if (pop_s) begin
      rd_next_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_next_s = rd_ptr_r;
    end

    // The new entry becomes head when it lands on the slot the read pointer moves to.
    if (push_s && (wr_ptr_r == rd_next_s)) begin
      head_next_s = entry_s;
    end else begin
      head_next_s = mem_r[rd_next_s];
    end

    case ({push_s, pop_s})
      2'b10:   fill_next_s = fill_r + CNT_ONE;
      2'b01:   fill_next_s = fill_r - CNT_ONE;
      default: fill_next_s = fill_r;
    endcase
  end

  // Synchronizer chains, history flops and the post-reset arming window.
  always_ff @(posedge clk) begin
    if (reset) begin
      udr_sync_r <= {SYNC_STAGES{1'b0}};
      uir_sync_r <= {SYNC_STAGES{1'b0}};
      udr_hist_r <= 1'b0;
      uir_hist_r <= 1'b0;
      arm_cnt_r  <= {ARM_W{1'b0}};
    end else begin
      udr_sync_r <= {udr_sync_r[SYNC_STAGES-2:0], vs_udr};
      uir_sync_r <= {uir_sync_r[SYNC_STAGES-2:0], vs_uir};
      udr_hist_r <= udr_sync_r[SYNC_STAGES-1];
      uir_hist_r <= uir_sync_r[SYNC_STAGES-1];
      if (!armed_s) begin
        arm_cnt_r <= arm_cnt_r + ARM_ONE;
      end else begin
        arm_cnt_r <= arm_cnt_r;
      end
    end
  end

  // Queue storage; stale slots are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= entry_s;
    end
  end

  // Pointers, fill counter, registered head, pulse and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      fill_r      <= {CNT_W{1'b0}};
      head_r      <= {ENT_W{1'b0}};
      valid_r     <= 1'b0;
      uir_pulse_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      rd_ptr_r    <= rd_next_s;
      fill_r      <= fill_next_s;
      valid_r     <= (fill_next_s != {CNT_W{1'b0}});
      head_r      <= head_next_s;
      uir_pulse_r <= uir_edge_s;
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clr_overflow) begin
        overflow_r <= 1'b0;
      end
    end
  end

  assign cmd_valid                            = valid_r;
  assign {cmd_ir, cmd_data, cmd_take_action}  = head_r;
  assign uir_pulse                            = uir_pulse_r;
  assign fill_level                           = fill_r;
  assign overflow                             = overflow_r;

endmodule

// File: tb/tb_jtag_debug_cmd_queue.sv
// Bench for jtag_debug_cmd_queue: directed scenarios plus random traffic, every cycle
// compared against a queue-based model driven by the sampled input history.
module tb_jtag_debug_cmd_queue;
  localparam int DRW   = 38;
  localparam int IRW   = 2;
  localparam int DEPTH = 4;
  localparam int S     = 2;
  localparam int ACT   = DRW - 1;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int EW    = IRW + DRW + 1;

  logic           clk = 1'b0;
  logic           reset, vs_udr, vs_uir, cmd_ready, clr_overflow;
  logic [IRW-1:0] ir_in;
  logic [DRW-1:0] sr;
  logic           cmd_valid, cmd_take_action, uir_pulse, overflow;
  logic [IRW-1:0] cmd_ir;
  logic [DRW-1:0] cmd_data;
  logic [LW-1:0]  fill_level;

  int checks   = 0;
  int failures = 0;

  logic [EW-1:0] mq[$];
  bit            m_ovf;
  bit            exp_pulse;
  bit            udr_smp[$];
  bit            uir_smp[$];

  always #5 clk = ~clk;

  jtag_debug_cmd_queue #(
    .DR_WIDTH(DRW), .IR_WIDTH(IRW), .DEPTH(DEPTH), .SYNC_STAGES(S), .ACTION_BIT(ACT)
  ) dut (
    .clk(clk), .reset(reset), .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir_in), .sr(sr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
    .cmd_take_action(cmd_take_action), .uir_pulse(uir_pulse), .fill_level(fill_level),
    .overflow(overflow), .clr_overflow(clr_overflow)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A rise first sampled at edge k is pushed/pulsed at edge k+S, but only once armed.
  function automatic bit rise(bit s[$]);
    int n = s.size();
    if (n < S + 2) return 1'b0;
    return s[n-1-S] && !s[n-2-S];
  endfunction

  task automatic tick();
    bit push_ev, pop_ev, full;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      udr_smp.delete();
      uir_smp.delete();
      m_ovf     = 1'b0;
      exp_pulse = 1'b0;
    end else begin
      udr_smp.push_back(vs_udr);
      uir_smp.push_back(vs_uir);
      push_ev   = rise(udr_smp);
      exp_pulse = rise(uir_smp);
      pop_ev    = (mq.size() != 0) && cmd_ready;
      full      = (mq.size() == DEPTH);
      if (push_ev && full && !pop_ev) begin
        m_ovf = 1'b1;
      end else begin
        if (clr_overflow) m_ovf = 1'b0;
        if (pop_ev) void'(mq.pop_front());
        if (push_ev) mq.push_back({ir_in, sr, sr[ACT]});
      end
    end
    #1;
    chk("cmd_valid", 64'(cmd_valid), 64'(mq.size() != 0));
    chk("fill_level", 64'(fill_level), 64'(mq.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("uir_pulse", 64'(uir_pulse), 64'(exp_pulse));
    if (mq.size() != 0) begin
      chk("cmd_ir", 64'(cmd_ir), 64'(mq[0][EW-1 -: IRW]));
      chk("cmd_data", 64'(cmd_data), 64'(mq[0][DRW:1]));
      chk("cmd_take_action", 64'(cmd_take_action), 64'(mq[0][0]));
    end else if (reset) begin
      chk("reset_head", 64'({cmd_ir, cmd_data, cmd_take_action}), 64'(0));
    end
  endtask

  // rdy_at: -1 never, -2 every cycle, else the pulse cycle index with ready high.
  task automatic pulse(logic [IRW-1:0] ir, logic [DRW-1:0] d, int hi, int lo,
                       int rdy_at, int clr_at, bit with_uir);
    ir_in = ir;
    sr    = d;
    for (int i = 0; i < hi + lo; i++) begin
      vs_udr       = (i < hi);
      vs_uir       = with_uir && (i < hi);
      cmd_ready    = (rdy_at == -2) || (i == rdy_at);
      clr_overflow = (i == clr_at);
      tick();
    end
    cmd_ready    = 1'b0;
    clr_overflow = 1'b0;
  endtask

  task automatic drain(int n);
    cmd_ready = 1'b1;
    repeat (n) tick();
    cmd_ready = 1'b0;
  endtask

  task automatic do_reset(int cycles);
    reset = 1'b1;
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  initial begin
    int u_hi, u_lo, u_lo_tgt, i_hi, i_lo, i_lo_tgt;
    reset = 1'b1; vs_udr = 1'b0; vs_uir = 1'b0; cmd_ready = 1'b0; clr_overflow = 1'b0;
    ir_in = '0; sr = '0;

    // Reset state and arming window.
    do_reset(2);
    repeat (4) tick();

    // Single update, then one-cycle pop.
    pulse(2'b01, 38'h2_0000_00AB, 6, 2, -1, -1, 1'b0);
    chk("single_valid", 64'(cmd_valid), 64'(1));
    chk("single_data", 64'(cmd_data), 64'h2_0000_00AB);
    drain(1);
    chk("single_popped", 64'(fill_level), 64'(0));
    repeat (2) tick();

    // Fill past DEPTH, drain in order, clear overflow.
    for (int i = 1; i <= 5; i++) pulse(IRW'(i), DRW'(i), 2, 3, -1, -1, 1'b0);
    chk("fill_full", 64'(fill_level), 64'(DEPTH));
    chk("fill_ovf", 64'(overflow), 64'(1));
    drain(5);
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    chk("ovf_cleared", 64'(overflow), 64'(0));

    // Full with a pop on the same edge as the fifth push.
    for (int i = 1; i <= 4; i++) pulse(IRW'(i), DRW'(i), 2, 3, -1, -1, 1'b0);
    pulse(2'b11, DRW'(5), 2, 3, S, -1, 1'b0);
    chk("simul_no_ovf", 64'(overflow), 64'(0));
    chk("simul_full", 64'(fill_level), 64'(DEPTH));
    drain(5);

    // Pointer wrap with immediate pops.
    for (int i = 0; i < 10; i++) begin
      pulse(IRW'(i), DRW'(i) | (DRW'(i & 1) << ACT), 2, 3, -2, -1, 1'b0);
      chk("wrap_fill_le1", 64'(fill_level <= LW'(1)), 64'(1));
    end

    // Clear on the same edge as a dropped push keeps overflow set; uir pulse rides along.
    for (int i = 1; i <= 4; i++) pulse(IRW'(i), DRW'(i + 16), 2, 3, -1, -1, 1'b0);
    pulse(2'b10, DRW'(99), 3, 4, -1, S, 1'b1);
    chk("clr_vs_set", 64'(overflow), 64'(1));

    // Reset with entries queued; levels held high through reset release.
    drain(1);
    vs_udr = 1'b1; vs_uir = 1'b1;
    do_reset(1);
    chk("reset_flush", 64'(fill_level), 64'(0));
    repeat (8) tick();
    chk("held_high_nopush", 64'(cmd_valid), 64'(0));
    vs_udr = 1'b0; vs_uir = 1'b0;
    repeat (4) tick();

    // Standalone uir pulse.
    pulse(2'b00, DRW'(7), 3, 4, -1, -1, 1'b1);
    drain(2);

    // Random traffic with a mid-run reset.
    u_hi = 0; u_lo = 0; u_lo_tgt = 3; i_hi = 0; i_lo = 0; i_lo_tgt = 4;
    for (int c = 0; c < 900; c++) begin
      if (u_hi > 0) begin
        vs_udr = 1'b1; u_hi--;
      end else if (u_lo < u_lo_tgt) begin
        vs_udr = 1'b0; u_lo++;
      end else begin
        vs_udr = 1'b1; u_hi = $urandom_range(5, 2) - 1; u_lo = 0;
        u_lo_tgt = $urandom_range(8, 3);
        ir_in = IRW'($urandom); sr = DRW'({$urandom, $urandom});
      end
      if (i_hi > 0) begin
        vs_uir = 1'b1; i_hi--;
      end else if (i_lo < i_lo_tgt) begin
        vs_uir = 1'b0; i_lo++;
      end else begin
        vs_uir = 1'b1; i_hi = $urandom_range(4, 1) - 1; i_lo = 0;
        i_lo_tgt = $urandom_range(9, 2);
      end
      cmd_ready    = ($urandom_range(99, 0) < ((c < 450) ? 15 : 60));
      clr_overflow = ($urandom_range(99, 0) < 6);
      reset        = (c == 450) || (c == 451);
      tick();
    end
    reset = 1'b0; cmd_ready = 1'b0; clr_overflow = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
